// File: rtl/logic_capture_fifo.sv
// rtl/logic_capture_fifo.sv - width-converting capture FIFO with loss flag and drop counter
module logic_capture_fifo #(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 10,
    parameter int SIGNED    = 1,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [IN_WIDTH-1:0]        in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_lossy,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 drop_count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = OUT_WIDTH + 1;

    logic [OUT_WIDTH-1:0] conv_data;
    logic                 conv_lossy;

    // Conversion: narrowing truncates and flags value loss, widening extends and is never lossy
    generate
        if (OUT_WIDTH < IN_WIDTH) begin : g_narrow
            assign conv_data = in_data[OUT_WIDTH-1:0];
            if (SIGNED != 0) begin : g_signed
                // discarded bits plus the new sign bit must all agree
                logic [IN_WIDTH-OUT_WIDTH:0] upper;
                assign upper      = in_data[IN_WIDTH-1:OUT_WIDTH-1];
                assign conv_lossy = ~((&upper) | ~(|upper));
            end else begin : g_unsigned
                logic [IN_WIDTH-OUT_WIDTH-1:0] upper;
                assign upper      = in_data[IN_WIDTH-1:OUT_WIDTH];
                assign conv_lossy = |upper;
            end
        end else begin : g_wide
            if (SIGNED != 0) begin : g_signed
                assign conv_data = OUT_WIDTH'($signed(in_data));
            end else begin : g_unsigned
                assign conv_data = OUT_WIDTH'(in_data);
            end
            assign conv_lossy = 1'b0;
        end
    endgenerate

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic               pop;
    logic               push;
    logic               drop;

    assign full      = (level == LVL_W'(DEPTH));
    assign empty     = (level == '0);
    assign out_valid = ~empty;

    // a full FIFO still accepts a sample when the head leaves in the same cycle
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    // Entry storage; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {conv_lossy, conv_data};
        end
    end

    // Pointers, occupancy and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Show-ahead head, forced to zero when nothing is buffered
    assign head      = mem[rd_ptr];
    assign out_data  = empty ? '0 : head[OUT_WIDTH-1:0];
    assign out_lossy = ~empty & head[OUT_WIDTH];

endmodule

// File: doc/logic_capture_fifo.md
# logic_capture_fifo

Downstream capture stage for the logic test design's counter/width-conversion outputs. It samples a signed or unsigned input word each cycle it is presented and converts it to the output width by truncation or sign/zero extension. It flags any conversion that loses value information, buffers results in a small FIFO, and drains them over a valid/ready interface to the cocotb bench. It counts samples dropped because the FIFO was full.

## Interface
- IN_WIDTH, 17, input sample width in bits (≥2)
- OUT_WIDTH, 10, output sample width in bits (≥2)
- SIGNED, 1, 1: input is two's complement (sign-extend, signed loss check); 0: unsigned (zero-extend, unsigned loss check)
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  sample present this cycle
- in_data  input  IN_WIDTH  sample, bit IN_WIDTH-1 is MSB
- out_valid  output  1  head entry available
- out_ready  input  1  consumer accepts head entry
- out_data  output  OUT_WIDTH  converted head sample
- out_lossy  output  1  head sample lost information in conversion
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- level  output  $clog2(DEPTH)+1  current occupancy
- drop_count  output  8  samples rejected while full, saturating

## Operation
- Conversion (combinational on in_data, stored with the entry):
  - OUT_WIDTH < IN_WIDTH: data = in_data[OUT_WIDTH-1:0]. For SIGNED=1, lossy = 1 unless in_data[IN_WIDTH-1:OUT_WIDTH-1] are all equal. For SIGNED=0, lossy = 1 unless in_data[IN_WIDTH-1:OUT_WIDTH] are all zero.
  - OUT_WIDTH ≥ IN_WIDTH: SIGNED=1 replicates in_data[IN_WIDTH-1] into the upper bits; SIGNED=0 zero-fills them. lossy = 0.
- pop = out_valid & out_ready.
- push = in_valid & (~full | pop). A write into a full FIFO is accepted when a pop occurs in the same cycle.
- drop = in_valid & full & ~pop. drop_count increments by 1 and holds at 255.
- Entry storage: DEPTH × (OUT_WIDTH+1) array, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- level: +1 on push only, −1 on pop only, unchanged on both or neither.
- out_valid = ~empty. out_data and out_lossy show the head entry (show-ahead). When empty, out_data and out_lossy read 0.
- out_ready while empty has no effect.
- full = (level == DEPTH); empty = (level == 0).

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream):
  - out_valid=0, out_data=0, out_lossy=0, full=0, empty=1, level=0, drop_count=0, pointers=0.
  - Storage contents are don't-care.
- Reset asserted mid-operation discards all buffered entries immediately. No pop is reported while reset is high.
- Latency: a sample pushed at rising edge N into an empty FIFO drives out_valid=1 with its data after edge N (visible in cycle N+1). No combinational path from in_* to out_*.
- out_valid and out_data change only on clk edges or on reset.
- The head is held stable while out_valid=1 and out_ready=0.
- Back-to-back: with out_ready held 1 and in_valid held 1, the FIFO sustains one sample per cycle at level 1 after the first cycle.
- Simultaneous push and pop when full: level stays DEPTH, the sample is accepted, and drop_count is unchanged.
- Simultaneous push and pop when empty: only the push occurs, because out_valid=0.

## Test plan
- Reset, then hold in_valid=0 for 5 cycles -> out_valid=0, empty=1, level=0, drop_count=0 throughout.
- Defaults; push 17'h1FFC9 (−55) with out_ready=0 -> next cycle out_valid=1, out_data=10'h3C9, out_lossy=0, level=1. Push 300 -> its entry holds 10'h12C, lossy=0. Push 600 -> its entry holds 10'h258, lossy=1.
- Test SIGNED=1, IN_WIDTH=4, OUT_WIDTH=10:
  - Input 4'b1001 -> out_data 10'h3F9, lossy=0.
  - Rebuild with SIGNED=0; the same input -> 10'h009.
- Fill with 0,1,2,3 (out_ready=0), then push 4,5 -> full=1, level=4, drop_count=2. Then drain -> 0,1,2,3 in order, after which empty=1.
- Full FIFO, with in_valid=1 and out_ready=1 for 6 cycles on inputs 10..15:
  - level stays 4 and drop_count is unchanged.
  - Outputs are the previous 4 entries followed by 10, 11.
- Push 300 drops into a full FIFO -> drop_count saturates at 255. Assert reset mid-drain -> all outputs return to reset values in the same cycle.
